// File: rtl/tx_pcs_sequencer.sv
// TX PCS sequencer. It sends the start-up COM run, then passes MAC symbols to the
// 8b/10b encoder, and it preempts the MAC with periodic SKP ordered sets.
module tx_pcs_sequencer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int START_COMMAS = 4
) (
  input  logic       Bit_Rate_10,
  input  logic       Rst,
  input  logic       enable,
  input  logic       tx_valid,
  input  logic [7:0] data,
  input  logic       TXDataK,
  output logic       tx_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_enable,
  output logic       enable_PMA,
  output logic       skp_done
);

  localparam int IW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int CW = $clog2(START_COMMAS + 1);
  localparam int SW = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;

  localparam logic [IW-1:0] INT_LAST   = IW'(SKP_INTERVAL - 1);
  localparam logic [CW-1:0] COMMA_LAST = CW'(START_COMMAS - 1);
  localparam logic [SW-1:0] SKP_LAST   = SW'(SKP_LEN - 1);

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    SKP_COM,
    SKP_SYM
  } state_t;

  state_t          state;
  logic [IW-1:0]   int_cnt;
  logic [CW-1:0]   comma_cnt;
  logic [SW-1:0]   skp_cnt;
  logic            skp_pending;

  // A pending SKP blocks the MAC from the slot that carries its COM onwards.
  assign tx_ready = (state == DATA) && enable && !skp_pending;

  always_ff @(posedge Bit_Rate_10) begin
    if (!Rst) begin
      state       <= IDLE;
      enc_data    <= 8'h00;
      enc_k       <= 1'b0;
      enc_enable  <= 1'b0;
      enable_PMA  <= 1'b0;
      skp_done    <= 1'b0;
      int_cnt     <= '0;
      comma_cnt   <= '0;
      skp_cnt     <= '0;
      skp_pending <= 1'b0;
    end else begin
      enable_PMA <= enable;
      skp_done   <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        enc_data    <= 8'h00;
        enc_k       <= 1'b0;
        enc_enable  <= 1'b0;
        int_cnt     <= '0;
        comma_cnt   <= '0;
        skp_cnt     <= '0;
        skp_pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            enc_data   <= 8'h00;
            enc_k      <= 1'b0;
            enc_enable <= 1'b0;
            comma_cnt  <= '0;
            state      <= START;
          end
          START: begin
            enc_data   <= K_COM;
            enc_k      <= 1'b1;
            enc_enable <= 1'b1;
            comma_cnt  <= comma_cnt + 1'b1;
            if (comma_cnt == COMMA_LAST) state <= DATA;
          end
          DATA: begin
            enc_enable <= 1'b1;
            if (skp_pending) begin
              // This is the COM slot of the ordered set. The interval counter holds.
              enc_data <= K_COM;
              enc_k    <= 1'b1;
              skp_cnt  <= '0;
              state    <= SKP_SYM;
            end else begin
              if (tx_valid && tx_ready) begin
                enc_data <= data;
                enc_k    <= TXDataK;
              end else begin
                enc_data <= 8'h00;
                enc_k    <= 1'b0;
              end
              if (int_cnt == INT_LAST) begin
                int_cnt     <= '0;
                skp_pending <= 1'b1;
              end else begin
                int_cnt <= int_cnt + 1'b1;
              end
            end
          end
          SKP_SYM: begin
            enc_data   <= K_SKP;
            enc_k      <= 1'b1;
            enc_enable <= 1'b1;
            if (skp_cnt == SKP_LAST) begin
              skp_done    <= 1'b1;
              skp_pending <= 1'b0;
              state       <= DATA;
            end else begin
              skp_cnt <= skp_cnt + 1'b1;
            end
          end
          default: begin
            enc_data   <= 8'h00;
            enc_k      <= 1'b0;
            enc_enable <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
